// File: rtl/ssp_pkg.sv
// Shared SSP definitions: state encoding, default widths and helpers.
package ssp_pkg;

   localparam int unsigned SSP_DATA_W    = 8;
   localparam int unsigned SSP_CLK_DIV   = 2;
   localparam int unsigned SSP_BIT_CNT_W = $clog2(SSP_DATA_W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRAME = 2'd1,
      SHIFT = 2'd2
   } ssp_state_e;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned ssp_cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ssp_clk_div.sv
// Free-running serial clock generator; flags the pclk cycle of each rising serial edge.
module ssp_clk_div
   import ssp_pkg::*;
#(
   parameter int unsigned CLK_DIV = SSP_CLK_DIV
) (
   input  logic pclk,
   input  logic clear_b,
   output logic sspclkout,
   output logic tick_rise
);

   localparam int unsigned      CNT_W   = ssp_cnt_w(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] div_cnt;
   logic             wrap;

   assign wrap      = (div_cnt == CNT_MAX);
   assign tick_rise = wrap & ~sspclkout;

   // Half-period counter; sspclkout toggles on each wrap.
   always_ff @(posedge pclk or negedge clear_b) begin
      if (!clear_b) begin
         div_cnt   <= '0;
         sspclkout <= 1'b0;
      end else if (wrap) begin
         div_cnt   <= '0;
         sspclkout <= ~sspclkout;
      end else begin
         div_cnt   <= div_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/ssp_tx_ctrl.sv
// SSP transmit sequencer: pops the TX FIFO and serialises each word MSB-first behind a frame pulse.
module ssp_tx_ctrl
   import ssp_pkg::*;
#(
   parameter int unsigned DATA_W  = SSP_DATA_W,
   parameter int unsigned CLK_DIV = SSP_CLK_DIV
) (
   input  logic              pclk,
   input  logic              clear_b,
   input  logic              tmit,
   input  logic [DATA_W-1:0] txdata,
   output logic              remove,
   output logic              sspclkout,
   output logic              sspfssout,
   output logic              ssptxd,
   output logic              sspoe_b
);

   localparam int unsigned      BIT_W   = ssp_cnt_w(DATA_W);
   localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);

   ssp_state_e        state, state_nxt;
   logic [DATA_W-1:0] shift_reg, shift_nxt;
   logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
   logic              load_c;
   logic              tick_rise;
   logic              remove_nxt, fss_nxt, txd_nxt, oe_b_nxt;

   ssp_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .pclk      (pclk),
      .clear_b   (clear_b),
      .sspclkout (sspclkout),
      .tick_rise (tick_rise)
   );

   // State, datapath and registered pin outputs.
   always_ff @(posedge pclk or negedge clear_b) begin
      if (!clear_b) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         remove    <= 1'b0;
         sspfssout <= 1'b0;
         ssptxd    <= 1'b0;
         sspoe_b   <= 1'b1;
      end else begin
         state     <= state_nxt;
         shift_reg <= shift_nxt;
         bit_cnt   <= bit_cnt_nxt;
         remove    <= remove_nxt;
         sspfssout <= fss_nxt;
         ssptxd    <= txd_nxt;
         sspoe_b   <= oe_b_nxt;
      end
   end

   // Next state: every transition waits for a rising serial edge.
   always_comb begin
      state_nxt   = state;
      shift_nxt   = shift_reg;
      bit_cnt_nxt = bit_cnt;
      load_c      = 1'b0;
      if (tick_rise) begin
         unique case (state)
            IDLE: begin
               if (tmit) begin
                  load_c    = 1'b1;
                  shift_nxt = txdata;
                  state_nxt = FRAME;
               end
            end
            FRAME: begin
               state_nxt   = SHIFT;
               bit_cnt_nxt = BIT_MAX;
            end
            SHIFT: begin
               if (bit_cnt != '0) begin
                  shift_nxt   = {shift_reg[DATA_W-2:0], 1'b0};
                  bit_cnt_nxt = bit_cnt - BIT_W'(1);
               end else if (tmit) begin
                  load_c    = 1'b1;
                  shift_nxt = txdata;
                  state_nxt = FRAME;
               end else begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Pin values for the upcoming state; remove marks the capture cycle only.
   always_comb begin
      remove_nxt = load_c;
      fss_nxt    = 1'b0;
      txd_nxt    = 1'b0;
      oe_b_nxt   = 1'b1;
      unique case (state_nxt)
         FRAME: begin
            fss_nxt  = 1'b1;
            oe_b_nxt = 1'b0;
         end
         SHIFT: begin
            oe_b_nxt = 1'b0;
            txd_nxt  = shift_nxt[DATA_W-1];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ssp_tx_ctrl.sv
// Bench for ssp_tx_ctrl: two builds (CLK_DIV=2 and CLK_DIV=1), FIFO model, pin-level receiver scoreboard.
module tb_ssp_tx_ctrl;

   localparam int CD0   = 2;
   localparam int CD1   = 1;
   localparam int DEPTH = 256;

   logic       pclk = 1'b0;
   logic       clear_b;
   logic       tmit_a    [2];
   logic [7:0] txdata_a  [2];
   logic       remove_a  [2];
   logic       sclk_a    [2];
   logic       fss_a     [2];
   logic       txd_a     [2];
   logic       oe_b_a    [2];

   // FIFO contents double as the expected transmit order.
   logic [7:0] fifo_mem [2][DEPTH];
   int wr  [2] = '{0, 0};
   int rd  [2] = '{0, 0};
   int got [2] = '{0, 0};
   int cyc      = 0;
   int n_checks = 0;
   int n_errors = 0;

   // Receiver / timing monitor state
   logic       prev_sclk [2];
   logic       prev_rm   [2];
   logic       in_word   [2];
   logic       tog_v     [2];
   logic       last_rm_v [2];
   logic       tmit_at   [2];
   logic [7:0] sh        [2];
   int         nbits     [2];
   int         fss_run   [2];
   int         since_tog [2];
   int         last_rm   [2];

   always #5 pclk = ~pclk;

   assign tmit_a[0]   = (wr[0] != rd[0]);
   assign tmit_a[1]   = (wr[1] != rd[1]);
   assign txdata_a[0] = fifo_mem[0][rd[0][7:0]];
   assign txdata_a[1] = fifo_mem[1][rd[1][7:0]];

   ssp_tx_ctrl #(.DATA_W(8), .CLK_DIV(CD0)) u_dut0 (
      .pclk(pclk), .clear_b(clear_b), .tmit(tmit_a[0]), .txdata(txdata_a[0]),
      .remove(remove_a[0]), .sspclkout(sclk_a[0]), .sspfssout(fss_a[0]),
      .ssptxd(txd_a[0]), .sspoe_b(oe_b_a[0]));

   ssp_tx_ctrl #(.DATA_W(8), .CLK_DIV(CD1)) u_dut1 (
      .pclk(pclk), .clear_b(clear_b), .tmit(tmit_a[1]), .txdata(txdata_a[1]),
      .remove(remove_a[1]), .sspclkout(sclk_a[1]), .sspfssout(fss_a[1]),
      .ssptxd(txd_a[1]), .sspoe_b(oe_b_a[1]));

   task automatic check(input string name, input int k, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", name, k, act, exp, cyc);
      end
   endtask

   task automatic push(input int k, input logic [7:0] b);
      if (wr[k] < DEPTH) begin
         fifo_mem[k][wr[k][7:0]] = b;
         wr[k] = wr[k] + 1;
      end
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((got[0] != wr[0] || got[1] != wr[1]) && n < budget) begin
         @(posedge pclk);
         n++;
      end
      if (n >= budget) begin
         check("drain_timeout", 0, got[0], wr[0]);
         check("drain_timeout", 1, got[1], wr[1]);
      end
      repeat (40) @(posedge pclk);
      #1;
   endtask

   // FIFO model: pops on the edge after remove is seen high.
   always @(posedge pclk) begin
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++)
         if (remove_a[k] === 1'b1) rd[k] <= rd[k] + 1;
   end

   // Pin monitor: decodes frames at falling serial edges and checks timing rules.
   always @(negedge pclk) begin : mon
      int cdv;
      int fr;
      int d;
      for (int k = 0; k < 2; k++) begin
         cdv = (k == 0) ? CD0 : CD1;
         fr  = 2 * cdv * 9;
         if (clear_b !== 1'b1) begin
            check("remove_in_reset", k, int'(remove_a[k]), 0);
            got[k]       = rd[k];
            in_word[k]   = 1'b0;
            nbits[k]     = 0;
            fss_run[k]   = 0;
            tog_v[k]     = 1'b0;
            since_tog[k] = 0;
            last_rm_v[k] = 1'b0;
            prev_sclk[k] = 1'b0;
            prev_rm[k]   = 1'b0;
         end else begin
            // Serial clock half-period
            if (sclk_a[k] !== prev_sclk[k]) begin
               if (tog_v[k]) check("sclk_half_period", k, since_tog[k], cdv);
               tog_v[k]     = 1'b1;
               since_tog[k] = 1;
            end else begin
               since_tog[k]++;
            end

            // Pop discipline
            if (remove_a[k] === 1'b1) begin
               check("remove_width", k, int'(prev_rm[k]), 0);
               check("remove_nonempty", k, int'(wr[k] > rd[k]), 1);
               check("remove_on_rise", k, int'({prev_sclk[k], sclk_a[k]}), 1);
            end
            if (last_rm_v[k]) begin
               d = cyc - last_rm[k];
               if (d == fr - 1) tmit_at[k] = tmit_a[k];
               if (d == fr) begin
                  check("b2b_remove", k, int'(remove_a[k]), int'(tmit_at[k]));
                  last_rm_v[k] = 1'b0;
               end else if (d > 0 && d < fr && remove_a[k] === 1'b1) begin
                  check("remove_spacing", k, d, fr);
               end
            end
            if (remove_a[k] === 1'b1) begin
               last_rm[k]   = cyc;
               last_rm_v[k] = 1'b1;
            end

            // Frame pulse width
            if (fss_a[k] === 1'b1) begin
               fss_run[k]++;
            end else if (fss_run[k] > 0) begin
               check("fss_width", k, fss_run[k], 2 * cdv);
               fss_run[k] = 0;
            end

            // Falling serial edge: receiver sample point
            if (prev_sclk[k] === 1'b1 && sclk_a[k] === 1'b0) begin
               if (fss_a[k] === 1'b1) begin
                  check("frame_restart", k, int'(in_word[k]), 0);
                  check("frame_pins", k, int'({oe_b_a[k], txd_a[k]}), 0);
                  in_word[k] = 1'b1;
                  nbits[k]   = 0;
                  sh[k]      = 8'h00;
               end else if (in_word[k]) begin
                  check("shift_oe", k, int'(oe_b_a[k]), 0);
                  sh[k] = {sh[k][6:0], txd_a[k]};
                  nbits[k]++;
                  if (nbits[k] == 8) begin
                     check("word", k, int'(sh[k]),
                           (got[k] < wr[k]) ? int'(fifo_mem[k][got[k][7:0]]) : -1);
                     got[k]++;
                     in_word[k] = 1'b0;
                  end
               end else begin
                  check("idle_pins", k, int'({oe_b_a[k], txd_a[k]}), 2);
               end
            end
            prev_sclk[k] = sclk_a[k];
            prev_rm[k]   = remove_a[k];
         end
      end
   end

   initial begin
      int n;
      clear_b = 1'b0;
      repeat (3) @(posedge pclk);
      #1 clear_b = 1'b1;

      // Idle with an empty FIFO
      repeat (100) @(posedge pclk);
      #1;

      // Single word per build
      push(0, 8'hA5);
      push(1, 8'hC3);
      wait_drain(2000);

      // Back-to-back pair
      push(0, 8'h81); push(0, 8'h3C);
      push(1, 8'h81); push(1, 8'h3C);
      wait_drain(2000);

      // Asynchronous reset in the middle of a word
      push(0, 8'hFF);
      push(1, 8'h96);
      n = 0;
      while (remove_a[0] !== 1'b1 && n < 200) begin
         @(negedge pclk);
         n++;
      end
      if (n >= 200) check("wait_remove", 0, int'(remove_a[0]), 1);
      repeat (22) @(negedge pclk);
      #1 clear_b = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check("rst_remove", k, int'(remove_a[k]), 0);
         check("rst_sclk",   k, int'(sclk_a[k]),   0);
         check("rst_fss",    k, int'(fss_a[k]),    0);
         check("rst_txd",    k, int'(txd_a[k]),    0);
         check("rst_oe_b",   k, int'(oe_b_a[k]),   1);
      end
      push(0, 8'h6B);
      repeat (5) @(negedge pclk);
      #1 clear_b = 1'b1;
      wait_drain(2000);

      // Word whose tmit drops while it is shifting
      push(0, 8'h55);
      push(1, 8'h55);
      wait_drain(2000);

      // Randomised bursts and gaps
      for (int i = 0; i < 40; i++) begin
         int k;
         int nb;
         k  = int'($urandom_range(0, 1));
         nb = int'($urandom_range(1, 3));
         for (int j = 0; j < nb; j++) push(k, 8'($urandom_range(1, 255)));
         repeat ($urandom_range(0, 60)) @(posedge pclk);
         #1;
      end
      wait_drain(20000);

      for (int k = 0; k < 2; k++) check("words_received", k, got[k], wr[k]);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
